tape_transport_ctrl: RTL and testbench
======================================

TAPE_TRANSPORT_CTRL -- requirements
Module: tape_transport_ctrl

Interface
REQ-001 Parameters: CLK_FREQ 27000000 (Hz); DEB_MS 20 (debounce); SILENCE_MS 2000 (no-edge timeout); ARM_MS 10000 (armed-wait timeout); REC_MAX_MS 8192; PLAY_MAX_MS 8192; GAP_MS 10 (forced-idle hold).
REQ-002 clk  in  1  system clock; reset reset_n, asynchronous, active-low; clock clk.
REQ-003 reset_n  in  1  asynchronous active-low reset.
REQ-004 key_play, key_rec, key_stop  in  1 each  raw asynchronous push buttons, active-high, bouncy.
REQ-005 mic_in  in  1  Spectrum MIC signal, asynchronous.
REQ-006 ear_in  in  1  recorder playback output, asynchronous, idles high.
REQ-007 rec_en, play_en  out  1 each  level commands to the tape recorder.
REQ-008 state  out  3  current state code; busy  out  1  state != IDLE.
REQ-009 done  out  1  one-cycle pulse when a session ends; stop_cause  out  2  valid with done, held until next done.

Function
REQ-010 Each key: 2-FF synchroniser, then accepted as pressed/released only after DEB_MS consecutive ms ticks stable; a rising debounced edge yields one 1-clk pulse.
REQ-011 mic_in and ear_in: 2-FF synchronised; an edge is any change versus the previous synchronised sample.
REQ-012 ms tick: free-running prescaler, 1-clk pulse every CLK_FREQ/1000 clocks; all timeouts count ticks, so actual duration lies in [N-1, N] ms after the counter clears.
REQ-013 States/codes: IDLE=0, ARM=1, RECORD=2, PLAY=3, GAP=4; codes 5-7 unreachable and go to GAP.
REQ-014 IDLE: rec pulse -> ARM; play pulse -> PLAY; stop pulse ignored; rec and play in the same cycle -> ARM.
REQ-015 ARM: first mic edge -> RECORD; stop pulse -> GAP with cause 0; ARM_MS without mic edge -> GAP with cause 3; rec/play pulses ignored.
REQ-016 RECORD: stop pulse -> GAP cause 0; SILENCE_MS without mic edge -> GAP cause 1; REC_MAX_MS since entry -> GAP cause 2; priority stop > max > silence.
REQ-017 PLAY: stop pulse -> GAP cause 0; SILENCE_MS without ear edge -> GAP cause 1; PLAY_MAX_MS since entry -> GAP cause 2; same priority.
REQ-018 GAP: rec_en=play_en=0 for GAP_MS ms, then IDLE; all key pulses in GAP discarded, not queued.
REQ-019 Silence counter clears on state entry and on every relevant edge; run counter clears on state entry only; counters saturate, never wrap.
REQ-020 Outputs are registered, updated on the same edge as the state register: rec_en=1 exactly in RECORD, play_en=1 exactly in PLAY, never both.
REQ-021 done pulses on the edge entering GAP from ARM, RECORD or PLAY; stop_cause updated on that same edge.
REQ-022 Counters at least 16 bits for ms counts; prescaler width ceil(log2(CLK_FREQ/1000)).

Reset
REQ-023 Asynchronous reset: state=IDLE, rec_en=0, play_en=0, busy=0, done=0, stop_cause=0, all counters, synchronisers and debounce states cleared (keys treated as released).
REQ-024 Reset mid-RECORD/PLAY drops rec_en/play_en immediately without done; after release the block waits in IDLE for a fresh pulse.

Structure
REQ-025 Package tape_ctrl_pkg holds state codes and stop_cause codes (KEY=0, SILENCE=1, MAX=2, ARM_TO=3).
REQ-026 Sub-module key_debounce (synchroniser + stable counter + edge pulse) instantiated three times, sharing the ms tick.

Verification (CLK_FREQ=100000, DEB_MS=2, SILENCE_MS=5, ARM_MS=8, REC_MAX_MS=20, PLAY_MAX_MS=20, GAP_MS=3)
REQ-027 key_rec bouncing 0.5 ms then held 3 ms, mic toggling every 1 ms -> state 1 then 2, rec_en=1 on entry to RECORD, exactly one ARM entry.
REQ-028 In RECORD, mic stops toggling -> GAP after 4-5 ms, done pulse, stop_cause=1, rec_en=0, IDLE 2-3 ms later.
REQ-029 key_play, ear toggling every 1 ms for 30 ms -> play_en high, exit at 19-20 ms with stop_cause=2.
REQ-030 key_rec then no mic edge -> ARM timeout at 7-8 ms, stop_cause=3, rec_en never asserted.
REQ-031 key_stop during PLAY, key_rec pressed during GAP -> stop_cause=0, GAP lasts 2-3 ms, then IDLE with no ARM entry.
REQ-032 reset_n low mid-RECORD -> rec_en=0 asynchronously, no done, state=0 after release.

Source files
------------

// File: rtl/tape_ctrl_pkg.sv
// Shared state codes, stop causes and helpers for the tape transport controller.
// Imported by the controller top and by its key debouncer.
package tape_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_RECORD = 3'd2,
        ST_PLAY   = 3'd3,
        ST_GAP    = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_KEY     = 2'd0,
        CAUSE_SILENCE = 2'd1,
        CAUSE_MAX     = 2'd2,
        CAUSE_ARM_TO  = 2'd3
    } cause_e;

    localparam int MS_CNT_W  = 16;
    localparam int KIDX_PLAY = 0;
    localparam int KIDX_REC  = 1;
    localparam int KIDX_STOP = 2;

    // Millisecond counters stick at all-ones instead of wrapping back to a short count.
    function automatic logic [MS_CNT_W-1:0] sat_inc(input logic [MS_CNT_W-1:0] v);
        return (&v) ? v : v + MS_CNT_W'(1);
    endfunction

endpackage

// File: rtl/tape_transport_ctrl_key_debounce.sv
// One push-button: 2-FF synchroniser, ms-tick stability counter and press pulse.
// The pulse is registered on the same edge the debounced level rises.
module key_debounce
    import tape_ctrl_pkg::*;
#(
    parameter int DEB_MS = 20
) (
    input  logic clk,
    input  logic reset_n,
    input  logic ms_tick,
    input  logic key_raw,
    output logic key_pulse
);

    logic                sync1_q;
    logic                sync2_q;
    logic                deb_q;
    logic                deb_d;
    logic                pulse_q;
    logic                pulse_d;
    logic [MS_CNT_W-1:0] stab_q;
    logic [MS_CNT_W-1:0] stab_d;

    always_comb begin
        deb_d  = deb_q;
        stab_d = stab_q;
        // Any sample that agrees with the accepted level restarts the stability window.
        if (sync2_q == deb_q) begin
            stab_d = '0;
        end else if (ms_tick) begin
            if (stab_q >= MS_CNT_W'(DEB_MS - 1)) begin
                deb_d  = sync2_q;
                stab_d = '0;
            end else begin
                stab_d = stab_q + MS_CNT_W'(1);
            end
        end
        pulse_d = deb_d & ~deb_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            pulse_q <= 1'b0;
            stab_q  <= '0;
        end else begin
            sync1_q <= key_raw;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            pulse_q <= pulse_d;
            stab_q  <= stab_d;
        end
    end

    assign key_pulse = pulse_q;

endmodule

// File: rtl/tape_transport_ctrl.sv
// Tape recorder transport controller: debounced keys, MIC/EAR activity timeouts,
// and the IDLE/ARM/RECORD/PLAY/GAP session state machine with registered outputs.
module tape_transport_ctrl
    import tape_ctrl_pkg::*;
#(
    parameter int CLK_FREQ    = 27000000,
    parameter int DEB_MS      = 20,
    parameter int SILENCE_MS  = 2000,
    parameter int ARM_MS      = 10000,
    parameter int REC_MAX_MS  = 8192,
    parameter int PLAY_MAX_MS = 8192,
    parameter int GAP_MS      = 10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       key_play,
    input  logic       key_rec,
    input  logic       key_stop,
    input  logic       mic_in,
    input  logic       ear_in,
    output logic       rec_en,
    output logic       play_en,
    output logic [2:0] state,
    output logic       busy,
    output logic       done,
    output logic [1:0] stop_cause
);

    localparam int DIV   = CLK_FREQ / 1000;
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PRE_W-1:0]    pre_q;
    logic [PRE_W-1:0]    pre_d;
    logic                ms_tick;
    logic [2:0]          key_raw;
    logic [2:0]          key_pulse;
    logic [2:0]          mic_sync_q;
    logic [2:0]          mic_sync_d;
    logic [2:0]          ear_sync_q;
    logic [2:0]          ear_sync_d;
    logic                mic_edge;
    logic                ear_edge;
    logic                play_pulse;
    logic                rec_pulse;
    logic                stop_pulse;

    state_e              state_q;
    state_e              state_d;
    cause_e              stop_cause_q;
    cause_e              stop_cause_d;
    logic                done_q;
    logic                done_d;
    logic                rec_en_q;
    logic                rec_en_d;
    logic                play_en_q;
    logic                play_en_d;
    logic                busy_q;
    logic                busy_d;
    logic [MS_CNT_W-1:0] silence_q;
    logic [MS_CNT_W-1:0] silence_d;
    logic [MS_CNT_W-1:0] run_q;
    logic [MS_CNT_W-1:0] run_d;
    logic                activity;

    // Free-running ms prescaler; every timeout in the block counts these ticks.
    always_comb begin
        ms_tick = (pre_q == PRE_W'(DIV - 1));
        pre_d   = ms_tick ? '0 : pre_q + PRE_W'(1);
    end

    assign key_raw = {key_stop, key_rec, key_play};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_key
            key_debounce #(
                .DEB_MS(DEB_MS)
            ) u_deb (
                .clk      (clk),
                .reset_n  (reset_n),
                .ms_tick  (ms_tick),
                .key_raw  (key_raw[gi]),
                .key_pulse(key_pulse[gi])
            );
        end
    endgenerate

    assign play_pulse = key_pulse[KIDX_PLAY];
    assign rec_pulse  = key_pulse[KIDX_REC];
    assign stop_pulse = key_pulse[KIDX_STOP];

    // Two flops of synchronisation plus one of history for change detection.
    always_comb begin
        mic_sync_d = {mic_sync_q[1:0], mic_in};
        ear_sync_d = {ear_sync_q[1:0], ear_in};
        mic_edge   = mic_sync_q[2] ^ mic_sync_q[1];
        ear_edge   = ear_sync_q[2] ^ ear_sync_q[1];
    end

    always_comb begin
        state_d      = state_q;
        stop_cause_d = stop_cause_q;
        done_d       = 1'b0;
        activity     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rec_pulse) begin
                    state_d = ST_ARM;
                end else if (play_pulse) begin
                    state_d = ST_PLAY;
                end
            end
            ST_ARM: begin
                activity = mic_edge;
                if (stop_pulse) begin
                    state_d      = ST_GAP;
                    stop_cause_d = CAUSE_KEY;
                    done_d       = 1'b1;
                end else if (mic_edge) begin
                    state_d = ST_RECORD;
                end else if (silence_q >= MS_CNT_W'(ARM_MS)) begin
                    state_d      = ST_GAP;
                    stop_cause_d = CAUSE_ARM_TO;
                    done_d       = 1'b1;
                end
            end
            ST_RECORD: begin
                activity = mic_edge;
                if (stop_pulse) begin
                    state_d      = ST_GAP;
                    stop_cause_d = CAUSE_KEY;
                    done_d       = 1'b1;
                end else if (run_q >= MS_CNT_W'(REC_MAX_MS)) begin
                    state_d      = ST_GAP;
                    stop_cause_d = CAUSE_MAX;
                    done_d       = 1'b1;
                end else if (silence_q >= MS_CNT_W'(SILENCE_MS)) begin
                    state_d      = ST_GAP;
                    stop_cause_d = CAUSE_SILENCE;
                    done_d       = 1'b1;
                end
            end
            ST_PLAY: begin
                activity = ear_edge;
                if (stop_pulse) begin
                    state_d      = ST_GAP;
                    stop_cause_d = CAUSE_KEY;
                    done_d       = 1'b1;
                end else if (run_q >= MS_CNT_W'(PLAY_MAX_MS)) begin
                    state_d      = ST_GAP;
                    stop_cause_d = CAUSE_MAX;
                    done_d       = 1'b1;
                end else if (silence_q >= MS_CNT_W'(SILENCE_MS)) begin
                    state_d      = ST_GAP;
                    stop_cause_d = CAUSE_SILENCE;
                    done_d       = 1'b1;
                end
            end
            ST_GAP: begin
                // Key pulses arriving here are simply dropped.
                if (run_q >= MS_CNT_W'(GAP_MS)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_GAP;
            end
        endcase

        silence_d = silence_q;
        run_d     = run_q;
        if (ms_tick) begin
            silence_d = sat_inc(silence_q);
            run_d     = sat_inc(run_q);
        end
        if (activity) begin
            silence_d = '0;
        end
        if (state_d != state_q) begin
            silence_d = '0;
            run_d     = '0;
        end

        rec_en_d  = (state_d == ST_RECORD);
        play_en_d = (state_d == ST_PLAY);
        busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_q        <= '0;
            mic_sync_q   <= '0;
            ear_sync_q   <= '0;
            state_q      <= ST_IDLE;
            stop_cause_q <= CAUSE_KEY;
            done_q       <= 1'b0;
            rec_en_q     <= 1'b0;
            play_en_q    <= 1'b0;
            busy_q       <= 1'b0;
            silence_q    <= '0;
            run_q        <= '0;
        end else begin
            pre_q        <= pre_d;
            mic_sync_q   <= mic_sync_d;
            ear_sync_q   <= ear_sync_d;
            state_q      <= state_d;
            stop_cause_q <= stop_cause_d;
            done_q       <= done_d;
            rec_en_q     <= rec_en_d;
            play_en_q    <= play_en_d;
            busy_q       <= busy_d;
            silence_q    <= silence_d;
            run_q        <= run_d;
        end
    end

    assign state      = state_q;
    assign stop_cause = stop_cause_q;
    assign done       = done_q;
    assign rec_en     = rec_en_q;
    assign play_en    = play_en_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_tape_transport_ctrl.sv
// Randomized session scenarios for tape_transport_ctrl, checked against timing
// windows and outcomes derived from the controller's rules.
`timescale 1ns/1ps
module tb_tape_transport_ctrl;

    localparam int CLK_FREQ    = 100000;
    localparam int DEB_MS      = 2;
    localparam int SILENCE_MS  = 5;
    localparam int ARM_MS      = 8;
    localparam int REC_MAX_MS  = 20;
    localparam int PLAY_MAX_MS = 20;
    localparam int GAP_MS      = 3;
    localparam int MS          = CLK_FREQ / 1000;
    localparam int SLK         = 8;
    localparam int TOG_MAX     = 140;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ARM  = 3'd1;
    localparam logic [2:0] S_REC  = 3'd2;
    localparam logic [2:0] S_PLAY = 3'd3;
    localparam logic [2:0] S_GAP  = 3'd4;

    localparam int K_PLAY = 0;
    localparam int K_REC  = 1;
    localparam int K_STOP = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       key_play = 1'b0;
    logic       key_rec = 1'b0;
    logic       key_stop = 1'b0;
    logic       mic_in = 1'b0;
    logic       ear_in = 1'b1;
    logic       rec_en;
    logic       play_en;
    logic [2:0] state;
    logic       busy;
    logic       done;
    logic [1:0] stop_cause;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    tape_transport_ctrl #(
        .CLK_FREQ(CLK_FREQ), .DEB_MS(DEB_MS), .SILENCE_MS(SILENCE_MS), .ARM_MS(ARM_MS),
        .REC_MAX_MS(REC_MAX_MS), .PLAY_MAX_MS(PLAY_MAX_MS), .GAP_MS(GAP_MS)
    ) dut (
        .clk(clk), .reset_n(reset_n), .key_play(key_play), .key_rec(key_rec),
        .key_stop(key_stop), .mic_in(mic_in), .ear_in(ear_in), .rec_en(rec_en),
        .play_en(play_en), .state(state), .busy(busy), .done(done), .stop_cause(stop_cause)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Observer: state entry times, done pulses, and output consistency.
    int         entry_cyc [8];
    int         arm_entries = 0;
    int         rec_entries = 0;
    int         done_cnt = 0;
    int         inv_viol = 0;
    int         rec_hi = 0;
    logic [1:0] last_cause = 2'd0;
    logic [2:0] prev_state = 3'd0;

    initial begin
        for (int i = 0; i < 8; i++) entry_cyc[i] = 0;
        forever begin
            @(negedge clk);
            if (state !== prev_state) begin
                entry_cyc[state] = cyc;
                if (state == S_ARM) arm_entries++;
                if (state == S_REC) rec_entries++;
            end
            prev_state = state;
            if (done === 1'b1) begin
                done_cnt++;
                last_cause = stop_cause;
                if (state !== S_GAP) inv_viol++;
            end
            if (rec_en === 1'b1) rec_hi++;
            if (rec_en !== (state == S_REC) || play_en !== (state == S_PLAY) ||
                busy !== (state != S_IDLE) || (rec_en === 1'b1 && play_en === 1'b1))
                inv_viol++;
        end
    end

    // Background MIC / EAR activity with random spacing between edges.
    bit mic_on = 0;
    bit ear_on = 0;
    int last_mic_cyc = 0;
    initial begin
        int mic_cnt = 0;
        int ear_cnt = 0;
        forever begin
            @(negedge clk);
            if (mic_on) begin
                if (mic_cnt == 0) begin
                    mic_in = ~mic_in;
                    last_mic_cyc = cyc;
                    mic_cnt = $urandom_range(60, TOG_MAX);
                end else mic_cnt--;
            end
            if (ear_on) begin
                if (ear_cnt == 0) begin
                    ear_in = ~ear_in;
                    ear_cnt = $urandom_range(60, TOG_MAX);
                end else ear_cnt--;
            end
        end
    end

    initial begin
        #(60000 * 10);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] in_win(input int v, input int lo, input int hi);
        return (v >= lo && v <= hi) ? 32'd1 : 32'd0;
    endfunction

    task automatic set_key(input int k, input logic v);
        case (k)
            K_PLAY:  key_play = v;
            K_REC:   key_rec = v;
            default: key_stop = v;
        endcase
    endtask

    // Optional short bounce burst (well under 0.5 ms), then a clean hold and release.
    task automatic press(input int k, input bit bounce, input int hold, output int stable_at);
        if (bounce) begin
            int n;
            n = $urandom_range(2, 4);
            for (int i = 0; i < n; i++) begin
                set_key(k, 1'b1);
                repeat ($urandom_range(3, 6)) @(negedge clk);
                set_key(k, 1'b0);
                repeat ($urandom_range(3, 6)) @(negedge clk);
            end
        end
        set_key(k, 1'b1);
        stable_at = cyc;
        repeat (hold) @(negedge clk);
        set_key(k, 1'b0);
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int n;
        n = 0;
        while (state !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, state, s);
        #1;
    endtask

    task automatic settle();
        repeat (3 * MS) @(negedge clk);
    endtask

    task automatic scen_idle_stop();
        int st;
        int d0;
        d0 = done_cnt;
        press(K_STOP, 1'b1, 3 * MS, st);
        repeat (MS) @(negedge clk);
        check("idle_stop_state", state, S_IDLE);
        check("idle_stop_no_done", done_cnt - d0, 0);
        $display("txn idle_stop: state=%0d", state);
        settle();
    endtask

    task automatic scen_record();
        int st;
        int a0;
        int d0;
        int v0;
        int last;
        int lat;
        a0 = arm_entries; d0 = done_cnt; v0 = inv_viol;
        mic_on = 1;
        press(K_REC, 1'b1, 3 * MS, st);
        wait_state(S_REC, 3 * MS, "rec_reach_record");
        check("rec_en_in_record", rec_en, 1);
        lat = entry_cyc[S_ARM] - st;
        check($sformatf("rec_arm_lat=%0d", lat), in_win(lat, (DEB_MS - 1) * MS, DEB_MS * MS + SLK), 1);
        check("rec_arm_once", arm_entries - a0, 1);
        lat = entry_cyc[S_REC] - entry_cyc[S_ARM];
        check($sformatf("rec_arm_to_rec=%0d", lat), in_win(lat, 1, TOG_MAX + SLK), 1);
        repeat ($urandom_range(3, 8) * MS) @(negedge clk);
        mic_on = 0;
        #1;
        last = last_mic_cyc;
        wait_state(S_GAP, SILENCE_MS * MS + 2 * SLK, "rec_reach_gap");
        lat = entry_cyc[S_GAP] - last;
        check($sformatf("rec_silence_lat=%0d", lat),
              in_win(lat, (SILENCE_MS - 1) * MS, SILENCE_MS * MS + SLK), 1);
        check("rec_done_once", done_cnt - d0, 1);
        check("rec_cause", last_cause, 1);
        check("rec_en_off_gap", rec_en, 0);
        wait_state(S_IDLE, GAP_MS * MS + 2 * SLK, "rec_reach_idle");
        lat = entry_cyc[S_IDLE] - entry_cyc[S_GAP];
        check($sformatf("rec_gap_len=%0d", lat), in_win(lat, (GAP_MS - 1) * MS, GAP_MS * MS + SLK), 1);
        check("rec_invariants", inv_viol - v0, 0);
        $display("txn record: cause=%0d", last_cause);
        settle();
    endtask

    task automatic scen_play_max();
        int st;
        int d0;
        int v0;
        int lat;
        d0 = done_cnt; v0 = inv_viol;
        ear_on = 1;
        press(K_PLAY, 1'b1, 3 * MS, st);
        wait_state(S_PLAY, 3 * MS, "play_reach_play");
        check("play_en_in_play", play_en, 1);
        check("rec_en_off_play", rec_en, 0);
        lat = entry_cyc[S_PLAY] - st;
        check($sformatf("play_entry_lat=%0d", lat), in_win(lat, (DEB_MS - 1) * MS, DEB_MS * MS + SLK), 1);
        wait_state(S_GAP, PLAY_MAX_MS * MS + 2 * SLK, "play_reach_gap");
        lat = entry_cyc[S_GAP] - entry_cyc[S_PLAY];
        check($sformatf("play_max_lat=%0d", lat),
              in_win(lat, (PLAY_MAX_MS - 1) * MS, PLAY_MAX_MS * MS + SLK), 1);
        check("play_done_once", done_cnt - d0, 1);
        check("play_cause", last_cause, 2);
        wait_state(S_IDLE, GAP_MS * MS + 2 * SLK, "play_reach_idle");
        ear_on = 0;
        check("play_invariants", inv_viol - v0, 0);
        $display("txn play_max: cause=%0d", last_cause);
        settle();
    endtask

    task automatic scen_arm_timeout();
        int st;
        int d0;
        int r0;
        int h0;
        int lat;
        d0 = done_cnt; r0 = rec_entries; h0 = rec_hi;
        press(K_REC, $urandom_range(0, 1), 3 * MS, st);
        wait_state(S_GAP, ARM_MS * MS + 2 * SLK, "arm_reach_gap");
        lat = entry_cyc[S_GAP] - entry_cyc[S_ARM];
        check($sformatf("arm_to_lat=%0d", lat), in_win(lat, (ARM_MS - 1) * MS, ARM_MS * MS + SLK), 1);
        check("arm_cause", last_cause, 3);
        check("arm_done_once", done_cnt - d0, 1);
        check("arm_no_record", rec_entries - r0, 0);
        check("arm_rec_en_never", rec_hi - h0, 0);
        wait_state(S_IDLE, GAP_MS * MS + 2 * SLK, "arm_reach_idle");
        $display("txn arm_timeout: cause=%0d", last_cause);
        settle();
    endtask

    task automatic scen_stop_gap();
        int st;
        int d0;
        int a0;
        int lat;
        d0 = done_cnt;
        ear_on = 1;
        press(K_PLAY, 1'b0, 3 * MS, st);
        wait_state(S_PLAY, 3 * MS, "stop_reach_play");
        repeat ($urandom_range(1, 4) * MS) @(negedge clk);
        key_stop = 1'b1;
        wait_state(S_GAP, DEB_MS * MS + 2 * SLK, "stop_reach_gap");
        key_rec = 1'b1;
        a0 = arm_entries;
        check("stop_cause", last_cause, 0);
        check("stop_done_once", done_cnt - d0, 1);
        wait_state(S_IDLE, GAP_MS * MS + 2 * SLK, "stop_reach_idle");
        lat = entry_cyc[S_IDLE] - entry_cyc[S_GAP];
        check($sformatf("stop_gap_len=%0d", lat), in_win(lat, (GAP_MS - 1) * MS, GAP_MS * MS + SLK), 1);
        repeat (2 * MS) @(negedge clk);
        key_stop = 1'b0;
        key_rec = 1'b0;
        ear_on = 0;
        settle();
        check("stop_no_arm", arm_entries - a0, 0);
        check("stop_idle_after", state, S_IDLE);
        $display("txn stop_gap: cause=%0d", last_cause);
    endtask

    task automatic scen_reset_record();
        int st;
        int d0;
        int a0;
        mic_on = 1;
        press(K_REC, 1'b0, 3 * MS, st);
        wait_state(S_REC, 3 * MS, "rst_reach_record");
        repeat ($urandom_range(1, 4) * MS) @(negedge clk);
        d0 = done_cnt;
        #2 reset_n = 1'b0;
        #1;
        check("rst_rec_en_async", rec_en, 0);
        check("rst_state_async", state, S_IDLE);
        check("rst_busy_async", busy, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        a0 = arm_entries;
        repeat (3 * MS) @(negedge clk);
        mic_on = 0;
        check("rst_no_done", done_cnt - d0, 0);
        check("rst_idle_after", state, S_IDLE);
        check("rst_no_rearm", arm_entries - a0, 0);
        $display("txn reset_record: state=%0d", state);
        settle();
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_state", state, S_IDLE);
        check("reset_rec_en", rec_en, 0);
        check("reset_play_en", play_en, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_cause", stop_cause, 0);
        reset_n = 1'b1;
        settle();
        for (int it = 0; it < 2; it++) begin
            scen_idle_stop();
            scen_record();
            scen_play_max();
            scen_arm_timeout();
            scen_stop_gap();
        end
        scen_reset_record();
        check("invariants_total", inv_viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
